// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game controller and its apple picker.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_UP    = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      CELL_OFF    = 2'b00,
      CELL_GREEN  = 2'b01,
      CELL_RED    = 2'b10,
      CELL_ORANGE = 2'b11
   } cell_color_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT1 = 3'd1,
      ST_INIT2 = 3'd2,
      ST_PLACE = 3'd3,
      ST_RUN   = 3'd4,
      ST_OVER  = 3'd5
   } game_state_t;

   function automatic dir_t opposite_dir(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

   // Fibonacci LFSR, taps 8,6,5,4 (maximal length, zero state unreachable).
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/snake_apple_picker.sv
// Apple placement engine: random LFSR probes, then a wrapping linear scan.
// Reports a free cell on apple_we, or pulses full when every cell is occupied.
module snake_apple_picker
   import snake_pkg::*;
#(
   parameter int         GRID_W      = 8,
   parameter int         GRID_H      = 8,
   parameter int         APPLE_TRIES = 16,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   localparam int        CELLS       = GRID_W * GRID_H,
   localparam int        IDX_W       = $clog2(CELLS)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             occ_in,
   output logic [IDX_W-1:0] probe_idx,
   output logic [IDX_W-1:0] apple_idx,
   output logic             apple_we,
   output logic             full
);

   localparam int TRY_W  = $clog2(APPLE_TRIES + 1);
   localparam int SCAN_W = $clog2(CELLS + 1);

   logic [7:0]       lfsr_r;
   logic [IDX_W-1:0] probe_r;
   logic [IDX_W-1:0] apple_idx_r;
   logic [IDX_W-1:0] rand_idx_s;
   logic [IDX_W-1:0] probe_wrap_s;
   logic [TRY_W-1:0] try_r;
   logic [SCAN_W-1:0] scan_cnt_r;
   logic             active_r;
   logic             scan_r;
   logic             apple_we_r;
   logic             full_r;

   // Random candidate from the LFSR and the next index of the wrapping scan.
   always_comb begin
      rand_idx_s = IDX_W'({24'd0, lfsr_r} % 32'(CELLS));
      if (probe_r == IDX_W'(CELLS - 1)) begin
         probe_wrap_s = '0;
      end else begin
         probe_wrap_s = probe_r + IDX_W'(1);
      end
   end

   // One probe per cycle while active; the LFSR free-runs in every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_r      <= LFSR_SEED;
         probe_r     <= '0;
         apple_idx_r <= '0;
         try_r       <= '0;
         scan_cnt_r  <= '0;
         active_r    <= 1'b0;
         scan_r      <= 1'b0;
         apple_we_r  <= 1'b0;
         full_r      <= 1'b0;
      end else begin
         lfsr_r     <= lfsr_next(lfsr_r);
         apple_we_r <= 1'b0;
         full_r     <= 1'b0;
         if (start) begin
            active_r   <= 1'b1;
            scan_r     <= 1'b0;
            try_r      <= '0;
            scan_cnt_r <= '0;
            probe_r    <= rand_idx_s;
         end else if (active_r) begin
            if (!occ_in) begin
               apple_idx_r <= probe_r;
               apple_we_r  <= 1'b1;
               active_r    <= 1'b0;
            end else if (!scan_r) begin
               if (try_r == TRY_W'(APPLE_TRIES - 1)) begin
                  scan_r  <= 1'b1;
                  probe_r <= probe_wrap_s;
               end else begin
                  try_r   <= try_r + TRY_W'(1);
                  probe_r <= rand_idx_s;
               end
            end else if (scan_cnt_r == SCAN_W'(CELLS - 1)) begin
               full_r   <= 1'b1;
               active_r <= 1'b0;
            end else begin
               scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
               probe_r    <= probe_wrap_s;
            end
         end
      end
   end

   assign probe_idx = probe_r;
   assign apple_idx = apple_idx_r;
   assign apple_we  = apple_we_r;
   assign full      = full_r;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, move tick, direction filter, score and
// apple placement, driving the cell-grid control inputs.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int         GRID_W      = 8,
   parameter int         GRID_H      = 8,
   parameter int         TICK_DIV    = 25000000,
   parameter int         SCORE_W     = 8,
   parameter int         APPLE_TRIES = 16,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   localparam int        IDX_W       = $clog2(GRID_W * GRID_H)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_start,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               eat_apple,
   input  logic               game_over_in,
   input  logic               occ_in,
   output logic [IDX_W-1:0]   probe_idx,
   output logic [IDX_W-1:0]   apple_idx,
   output logic               apple_we,
   output logic               grid_reset,
   output logic               grid_start,
   output logic               move_tick,
   output logic [1:0]         direction,
   output logic [SCORE_W-1:0] score,
   output logic               playing,
   output logic               game_over,
   output logic               win
);

   localparam int TICK_W = $clog2(TICK_DIV);

   game_state_t        state_r;
   dir_t               direction_r;
   dir_t               pending_r;
   dir_t               req_dir_s;
   logic [SCORE_W-1:0] score_r;
   logic [TICK_W-1:0]  tick_cnt_r;
   logic [TICK_W-1:0]  tick_next_s;
   logic               tick_last_s;
   logic               eat_prev_r;
   logic               eat_rise_s;
   logic               btn_any_s;
   logic               dir_ok_s;
   logic               grid_reset_r;
   logic               grid_start_r;
   logic               move_tick_r;
   logic               playing_r;
   logic               game_over_r;
   logic               win_r;
   logic               pick_start_r;
   logic               apple_we_s;
   logic               full_s;

   // Button priority, reversal filter, eat edge detect and tick counter step.
   always_comb begin
      btn_any_s = btn_up | btn_down | btn_left | btn_right;
      if (btn_up) begin
         req_dir_s = DIR_UP;
      end else if (btn_down) begin
         req_dir_s = DIR_DOWN;
      end else if (btn_left) begin
         req_dir_s = DIR_LEFT;
      end else begin
         req_dir_s = DIR_RIGHT;
      end
      dir_ok_s    = btn_any_s && ((state_r == ST_RUN) || (state_r == ST_PLACE))
                    && (req_dir_s != opposite_dir(direction_r));
      eat_rise_s  = eat_apple & ~eat_prev_r;
      tick_last_s = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
      if (tick_last_s) begin
         tick_next_s = '0;
      end else begin
         tick_next_s = tick_cnt_r + TICK_W'(1);
      end
   end

   // Game FSM; move_tick_r tracks (RUN && counter at last count) one cycle ahead.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         direction_r  <= DIR_RIGHT;
         pending_r    <= DIR_RIGHT;
         score_r      <= '0;
         tick_cnt_r   <= '0;
         eat_prev_r   <= 1'b0;
         grid_reset_r <= 1'b1;
         grid_start_r <= 1'b0;
         move_tick_r  <= 1'b0;
         playing_r    <= 1'b0;
         game_over_r  <= 1'b0;
         win_r        <= 1'b0;
         pick_start_r <= 1'b0;
      end else begin
         eat_prev_r   <= eat_apple;
         pick_start_r <= 1'b0;
         move_tick_r  <= 1'b0;
         if (dir_ok_s) begin
            pending_r <= req_dir_s;
         end
         if (move_tick_r) begin
            direction_r <= pending_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (btn_start) begin
                  state_r      <= ST_INIT1;
                  grid_start_r <= 1'b1;
               end
            end
            ST_INIT1: begin
               state_r      <= ST_INIT2;
               grid_reset_r <= 1'b0;
               grid_start_r <= 1'b0;
            end
            ST_INIT2: begin
               state_r      <= ST_PLACE;
               score_r      <= '0;
               direction_r  <= DIR_RIGHT;
               pending_r    <= DIR_RIGHT;
               tick_cnt_r   <= '0;
               playing_r    <= 1'b1;
               pick_start_r <= 1'b1;
            end
            ST_PLACE: begin
               if (apple_we_s) begin
                  state_r     <= ST_RUN;
                  move_tick_r <= tick_last_s;
               end else if (full_s) begin
                  state_r     <= ST_OVER;
                  playing_r   <= 1'b0;
                  game_over_r <= 1'b1;
                  win_r       <= 1'b1;
               end
            end
            ST_RUN: begin
               tick_cnt_r <= tick_next_s;
               if (game_over_in) begin
                  state_r     <= ST_OVER;
                  playing_r   <= 1'b0;
                  game_over_r <= 1'b1;
                  win_r       <= 1'b0;
               end else if (eat_rise_s) begin
                  state_r      <= ST_PLACE;
                  pick_start_r <= 1'b1;
                  if (score_r != {SCORE_W{1'b1}}) begin
                     score_r <= score_r + SCORE_W'(1);
                  end
               end else begin
                  move_tick_r <= (tick_next_s == TICK_W'(TICK_DIV - 1));
               end
            end
            ST_OVER: begin
               if (btn_start) begin
                  state_r      <= ST_INIT1;
                  grid_reset_r <= 1'b1;
                  grid_start_r <= 1'b1;
                  game_over_r  <= 1'b0;
                  win_r        <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   snake_apple_picker #(
      .GRID_W      (GRID_W),
      .GRID_H      (GRID_H),
      .APPLE_TRIES (APPLE_TRIES),
      .LFSR_SEED   (LFSR_SEED)
   ) u_picker (
      .clk       (clk),
      .reset     (reset),
      .start     (pick_start_r),
      .occ_in    (occ_in),
      .probe_idx (probe_idx),
      .apple_idx (apple_idx),
      .apple_we  (apple_we_s),
      .full      (full_s)
   );

   assign apple_we   = apple_we_s;
   assign grid_reset = grid_reset_r;
   assign grid_start = grid_start_r;
   assign move_tick  = move_tick_r;
   assign direction  = direction_r;
   assign score      = score_r;
   assign playing    = playing_r;
   assign game_over  = game_over_r;
   assign win        = win_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl on a 2x2 grid with a short tick period.
module tb_snake_game_ctrl;

   localparam int GW = 2, GH = 2, CELLS = 4, TD = 4, SW = 2, TRIES = 5, IDX_W = 2;
   localparam logic [3:0] P1_T [7] = '{4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b1001, 4'b0001, 4'b0100};
   localparam logic [3:0] P2_T [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
   localparam logic [1:0] EX_T [7] = '{2'b00,   2'b11,   2'b11,   2'b00,   2'b11,   2'b00,   2'b11};
   localparam logic [3:0] OCC_T [4] = '{4'b1011, 4'b0111, 4'b1110, 4'b0000};

   logic clk, reset, btn_start, btn_up, btn_down, btn_left, btn_right;
   logic eat_apple, game_over_in, occ_in;
   logic [IDX_W-1:0] probe_idx, apple_idx;
   logic apple_we, grid_reset, grid_start, move_tick, playing, game_over, win;
   logic [1:0] direction;
   logic [SW-1:0] score;
   logic [CELLS-1:0] occ_map;

   int n_checks = 0;
   int n_fail   = 0;
   logic [SW-1:0]    score_q [$];
   logic [CELLS-1:0] apple_q [$];
   logic [SW-1:0]    prev_score = '0;
   logic [SW-1:0]    exp_score  = '0;

   snake_game_ctrl #(
      .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD), .SCORE_W(SW),
      .APPLE_TRIES(TRIES), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_up(btn_up),
      .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .eat_apple(eat_apple), .game_over_in(game_over_in), .occ_in(occ_in),
      .probe_idx(probe_idx), .apple_idx(apple_idx), .apple_we(apple_we),
      .grid_reset(grid_reset), .grid_start(grid_start), .move_tick(move_tick),
      .direction(direction), .score(score), .playing(playing),
      .game_over(game_over), .win(win)
   );

   assign occ_in = occ_map[probe_idx];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: pops expected score changes and apple placements as they appear.
   always @(negedge clk) begin
      if (!reset) begin
         prev_score = '0;
      end else begin
         if (score !== prev_score) begin
            n_checks++;
            if (score_q.size() == 0) begin
               n_fail++;
               $display("FAIL score_update: unexpected change to %0d", score);
            end else begin
               logic [SW-1:0] e;
               e = score_q.pop_front();
               if (score !== e) begin
                  n_fail++;
                  $display("FAIL score_update: got %0d expected %0d", score, e);
               end
            end
            prev_score = score;
         end
         if (apple_we === 1'b1) begin
            n_checks++;
            if (apple_q.size() == 0) begin
               n_fail++;
               $display("FAIL apple_we: unexpected pulse at idx %0d", apple_idx);
            end else begin
               logic [CELLS-1:0] m;
               m = apple_q.pop_front();
               if (m[apple_idx] !== 1'b0 || playing !== 1'b1) begin
                  n_fail++;
                  $display("FAIL apple_place: idx %0d occ_mask %b playing %b, required free cell while playing",
                           apple_idx, m, playing);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] b);
      {btn_up, btn_down, btn_left, btn_right} = b;
      step();
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
   endtask

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * TD; i++) begin
         step();
         if (move_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_apple(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < TRIES + CELLS + 8; i++) begin
         step();
         if (apple_we === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; btn_start = 1'b0; {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      eat_apple = 1'b0; game_over_in = 1'b0; occ_map = '0;
      repeat (3) step();
      n_checks++;
      if ({grid_reset, grid_start, move_tick, apple_we, playing, game_over, win} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 1000000",
                  {grid_reset, grid_start, move_tick, apple_we, playing, game_over, win});
      end
      n_checks++;
      if ({direction, score, apple_idx, probe_idx} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_values: dir %0d score %0d apple %0d probe %0d, all expected 0",
                  direction, score, apple_idx, probe_idx);
      end
      reset = 1'b1;
      repeat (2) step();
      n_checks++;
      if (grid_reset !== 1'b1 || playing !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: grid_reset %b playing %b expected 1 0", grid_reset, playing);
      end
   endtask

   task automatic test_start();
      bit ok;
      occ_map = 4'b0000;
      btn_start = 1'b1;
      apple_q.push_back(occ_map);
      step();
      btn_start = 1'b0;
      n_checks++;
      if (grid_reset !== 1'b1 || grid_start !== 1'b1) begin
         n_fail++;
         $display("FAIL init_cycle1: grid_reset %b grid_start %b expected 1 1", grid_reset, grid_start);
      end
      step();
      n_checks++;
      if (grid_reset !== 1'b0 || grid_start !== 1'b0) begin
         n_fail++;
         $display("FAIL init_cycle2: grid_reset %b grid_start %b expected 0 0", grid_reset, grid_start);
      end
      wait_apple(ok);
      n_checks++;
      if (!ok || playing !== 1'b1 || direction !== 2'b00 || score !== 2'd0) begin
         n_fail++;
         $display("FAIL first_apple: seen %b playing %b dir %0d score %0d expected 1 1 0 0",
                  ok, playing, direction, score);
      end
      step();
   endtask

   task automatic test_tick();
      bit ok;
      int bad = 0;
      int ticks = 0;
      wait_tick(ok);
      for (int i = 1; i <= 12; i++) begin
         step();
         if (move_tick === 1'b1) ticks++;
         if (move_tick !== ((i % TD) == 0)) bad++;
      end
      n_checks++;
      if (!ok || bad != 0 || ticks != 3) begin
         n_fail++;
         $display("FAIL tick_period: first %b misplaced %0d count %0d expected 1 0 3", ok, bad, ticks);
      end
   endtask

   task automatic test_direction();
      bit ok1, ok2;
      logic [1:0] cur = 2'b00;
      for (int r = 0; r < 7; r++) begin
         wait_tick(ok1);
         step();
         press(P1_T[r]);
         if (P2_T[r] != 4'b0000) press(P2_T[r]);
         wait_tick(ok2);
         n_checks++;
         if (!ok1 || !ok2 || direction !== cur) begin
            n_fail++;
            $display("FAIL dir_hold row %0d: ticks %b%b dir %0d expected %0d", r, ok1, ok2, direction, cur);
         end
         step();
         n_checks++;
         if (direction !== EX_T[r]) begin
            n_fail++;
            $display("FAIL dir_commit row %0d: got %0d expected %0d", r, direction, EX_T[r]);
         end
         cur = EX_T[r];
      end
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
      n_checks++;
      if (grid_reset !== 1'b0 || grid_start !== 1'b0 || playing !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_run: grid_reset %b grid_start %b playing %b expected 0 0 1",
                  grid_reset, grid_start, playing);
      end
   endtask

   task automatic test_score();
      bit found, tick_seen;
      for (int k = 0; k < 4; k++) begin
         int hold = (k == 0) ? 3 : 1;
         occ_map = OCC_T[k];
         eat_apple = 1'b1;
         if (exp_score != 2'b11) begin
            exp_score = exp_score + 2'b01;
            score_q.push_back(exp_score);
         end
         apple_q.push_back(occ_map);
         found = 1'b0;
         tick_seen = 1'b0;
         for (int i = 0; i < TRIES + CELLS + 8; i++) begin
            step();
            if (i == hold - 1) eat_apple = 1'b0;
            if (move_tick === 1'b1) tick_seen = 1'b1;
            if (apple_we === 1'b1) begin
               found = 1'b1;
               break;
            end
         end
         eat_apple = 1'b0;
         n_checks++;
         if (!found || tick_seen || score !== exp_score) begin
            n_fail++;
            $display("FAIL eat %0d: apple %b tick_in_place %b score %0d expected 1 0 %0d",
                     k, found, tick_seen, score, exp_score);
         end
         step();
      end
      n_checks++;
      if (score !== 2'b11) begin
         n_fail++;
         $display("FAIL score_saturate: got %0d expected 3", score);
      end
   endtask

   task automatic test_eat_gameover();
      eat_apple = 1'b1;
      game_over_in = 1'b1;
      step();
      eat_apple = 1'b0;
      game_over_in = 1'b0;
      n_checks++;
      if (game_over !== 1'b1 || win !== 1'b0 || playing !== 1'b0 || score !== 2'b11) begin
         n_fail++;
         $display("FAIL over_priority: over %b win %b playing %b score %0d expected 1 0 0 3",
                  game_over, win, playing, score);
      end
      press(4'b0001);
      repeat (3) step();
      n_checks++;
      if (game_over !== 1'b1 || direction !== 2'b11) begin
         n_fail++;
         $display("FAIL over_hold: over %b dir %0d expected 1 3", game_over, direction);
      end
   endtask

   task automatic test_full_grid();
      bit done = 1'b0;
      logic [CELLS-1:0] seen = '0;
      occ_map = 4'b1111;
      score_q.push_back(2'b00);
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      for (int i = 0; i < TRIES + CELLS + 12; i++) begin
         step();
         if (playing === 1'b1) seen[probe_idx] = 1'b1;
         if (game_over === 1'b1) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done || win !== 1'b1 || playing !== 1'b0 || seen !== 4'b1111) begin
         n_fail++;
         $display("FAIL full_grid: over %b win %b playing %b probed %b expected 1 1 0 1111",
                  done, win, playing, seen);
      end
   endtask

   task automatic test_reset_midplace();
      bit in_place = 1'b0;
      occ_map = 4'b1111;
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (playing === 1'b1) begin
            in_place = 1'b1;
            break;
         end
      end
      repeat (2) step();
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (!in_place || {grid_reset, grid_start, move_tick, apple_we, playing, game_over, win} !== 7'b1000000
          || {direction, score, apple_idx, probe_idx} !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: place %b flags %b dir %0d score %0d apple %0d probe %0d expected reset values",
                  in_place, {grid_reset, grid_start, move_tick, apple_we, playing, game_over, win},
                  direction, score, apple_idx, probe_idx);
      end
      step();
      reset = 1'b1;
      repeat (3) step();
      n_checks++;
      if (grid_reset !== 1'b1 || playing !== 1'b0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: grid_reset %b playing %b over %b expected 1 0 0",
                  grid_reset, playing, game_over);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_tick();
      test_direction();
      test_score();
      test_eat_gameover();
      test_full_grid();
      test_reset_midplace();
      n_checks++;
      if (score_q.size() != 0 || apple_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d scores and %0d apples outstanding, expected 0 0",
                  score_q.size(), apple_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
